// File: rtl/w_buffer.sv
// w_buffer: show-ahead FIFO of packed 32-bit weight words feeding the
// weight sub-word broadcast mux. The head word stays on rdata until every
// sub-word has been consumed (4 reads at 8b, 2 at 4b, 1 at 2b). Only then
// is it popped, so the local sub-word counter tracks the mux read pointer.
//
// Handshake: a write is taken on a rising clk edge when wr_en && !full. A
// sub-word read is taken when rd_en && !empty. full and empty are
// evaluated before that edge's pop and push. A refused write sets overflow
// and a refused read sets underflow. Neither refused request moves any
// pointer.
module w_buffer #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     nRST,
    input  logic [2:0]               input_bitwidth,
    input  logic                     wr_en,
    input  logic [DATA_WIDTH-1:0]    wdata,
    output logic                     full,
    input  logic                     rd_en,
    output logic [DATA_WIDTH-1:0]    rdata,
    output logic                     empty,
    output logic                     word_done,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     err_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Encodings shared with the mux
    localparam logic [2:0] BW_2B = 3'b001;
    localparam logic [2:0] BW_4B = 3'b010;
    localparam logic [2:0] BW_8B = 3'b100;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         cnt;
    logic [1:0]            sub_ptr;
    logic [1:0]            last;
    logic                  wr_ok;
    logic                  rd_ok;
    logic                  pop;

    assign empty = (cnt == '0);
    assign full  = (cnt == CW'(DEPTH));
    assign count = cnt;

    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;
    assign pop   = rd_ok && (sub_ptr >= last);

    assign word_done = pop;

    // Index of the final sub-word for the current width. Unknown encodings
    // fall back to 3, matching the mux's free-running mod-4 pointer.
    always_comb begin
        last = 2'd3;
        case (input_bitwidth)
            BW_8B:   last = 2'd3;
            BW_4B:   last = 2'd1;
            BW_2B:   last = 2'd0;
            default: last = 2'd3;
        endcase
    end

    // Show-ahead head word. It reads as zero when the FIFO holds nothing.
    always_comb begin
        rdata = '0;
        if (!empty) begin
            rdata = mem[rd_ptr];
        end
    end

    // Storage array. It is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Write pointer advances on every accepted write and wraps modulo DEPTH.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            wr_ptr <= '0;
        end else if (wr_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
        end
    end

    // Read pointer and sub-word counter move only on accepted reads.
    // The pointer advances only when the last sub-word is consumed.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            rd_ptr  <= '0;
            sub_ptr <= 2'd0;
        end else if (pop) begin
            rd_ptr  <= rd_ptr + AW'(1);
            sub_ptr <= 2'd0;
        end else if (rd_ok) begin
            sub_ptr <= sub_ptr + 2'd1;
        end
    end

    // Occupancy is accepted writes minus pops. A write and a pop together
    // leave it unchanged.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            cnt <= '0;
        end else begin
            case ({wr_ok, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Sticky error flags. A new error event in the same cycle as err_clr
    // takes priority, so the flag stays set.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (overflow  && !err_clr) || (wr_en && full);
            underflow <= (underflow && !err_clr) || (rd_en && empty);
        end
    end

endmodule

// File: tb/tb_w_buffer.sv
// Bench for w_buffer. Words are pushed onto an expected queue when a write
// is accepted. The head is compared against rdata every cycle and popped
// when the bench's own sub-word model says the word is complete.
module tb_w_buffer;

    localparam int DEPTH = 8;
    localparam int DW    = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          nRST;
    logic [2:0]    input_bitwidth;
    logic          wr_en;
    logic [DW-1:0] wdata;
    logic          full;
    logic          rd_en;
    logic [DW-1:0] rdata;
    logic          empty;
    logic          word_done;
    logic [CW-1:0] count;
    logic          overflow;
    logic          underflow;
    logic          err_clr;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] exp_q[$];
    int            m_sub;
    logic          m_ovf;
    logic          m_unf;

    w_buffer #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
        .clk            (clk),
        .nRST           (nRST),
        .input_bitwidth (input_bitwidth),
        .wr_en          (wr_en),
        .wdata          (wdata),
        .full           (full),
        .rd_en          (rd_en),
        .rdata          (rdata),
        .empty          (empty),
        .word_done      (word_done),
        .count          (count),
        .overflow       (overflow),
        .underflow      (underflow),
        .err_clr        (err_clr)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int last_of(input logic [2:0] bw);
        case (bw)
            3'b001:  return 0;
            3'b010:  return 1;
            default: return 3;
        endcase
    endfunction

    // Registered-state checks, taken 1 time unit after the active edge
    task automatic check_state(input string tag);
        check({tag, ".count"}, 64'(count), 64'(exp_q.size()));
        check({tag, ".empty"}, 64'(empty), 64'(exp_q.size() == 0));
        check({tag, ".full"}, 64'(full), 64'(exp_q.size() == DEPTH));
        check({tag, ".rdata"}, 64'(rdata), (exp_q.size() > 0) ? 64'(exp_q[0]) : 64'd0);
        check({tag, ".overflow"}, 64'(overflow), 64'(m_ovf));
        check({tag, ".underflow"}, 64'(underflow), 64'(m_unf));
    endtask

    // Driver: one clock cycle. Called 1 time unit after a rising edge.
    task automatic drive(input logic w, input logic [DW-1:0] d, input logic r, input logic clr);
        int  sz;
        bit  w_ok;
        bit  done;
        wr_en   = w;
        wdata   = d;
        rd_en   = r;
        err_clr = clr;
        #1;
        sz   = exp_q.size();
        w_ok = w && (sz < DEPTH);
        done = r && (sz > 0) && (m_sub >= last_of(input_bitwidth));
        check("word_done", 64'(word_done), 64'(done));
        if (clr) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (w && sz == DEPTH) m_ovf = 1'b1;
        if (r && sz == 0) m_unf = 1'b1;
        if (done) begin
            void'(exp_q.pop_front());
            m_sub = 0;
        end else if (r && sz > 0) begin
            m_sub++;
        end
        if (w_ok) exp_q.push_back(d);
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        err_clr = 1'b0;
        check_state("post");
    endtask

    task automatic wr(input logic [DW-1:0] d);
        drive(1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic rd();
        drive(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_sub = 0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    initial begin
        nRST           = 1'b0;
        input_bitwidth = 3'b100;
        wr_en          = 1'b0;
        wdata          = '0;
        rd_en          = 1'b0;
        err_clr        = 1'b0;
        model_reset();
        #22;
        nRST = 1'b1;
        @(posedge clk);
        #1;

        // reset state
        check_state("reset");
        check("reset.word_done", 64'(word_done), 64'd0);

        // 8b: one word, four sub-word reads
        input_bitwidth = 3'b100;
        wr(32'hDDCCBBAA);
        check("t1.head", 64'(rdata), 64'hDDCCBBAA);
        for (int i = 0; i < 4; i++) rd();
        check("t1.empty", 64'(empty), 64'd1);

        // 4b: two words, done on reads 2 and 4
        input_bitwidth = 3'b010;
        wr(32'h44332211);
        wr(32'h88776655);
        for (int i = 0; i < 4; i++) rd();

        // 2b: three words, rd_en held high
        input_bitwidth = 3'b001;
        wr(32'h0A0A0A0A);
        wr(32'h0B0B0B0B);
        wr(32'h0C0C0C0C);
        for (int i = 0; i < 3; i++) rd();

        // fill to DEPTH, overflow, drain across pointer wrap, clear
        for (int i = 0; i < DEPTH; i++) wr(32'h1000_0000 + 32'(i));
        check("t4.full", 64'(full), 64'd1);
        wr(32'hFFFFFFFF);
        check("t4.overflow", 64'(overflow), 64'd1);
        // full refuses a write even alongside a pop
        drive(1'b1, 32'hEEEEEEEE, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH - 1; i++) rd();
        drive(1'b0, '0, 1'b0, 1'b1);
        check("t4.ovf_clr", 64'(overflow), 64'd0);

        // simultaneous write and pop at count 3
        for (int i = 0; i < 3; i++) wr(32'h2000_0000 + 32'(i));
        drive(1'b1, 32'h2000_0003, 1'b1, 1'b0);
        check("t5.count", 64'(count), 64'd3);
        for (int i = 0; i < 2; i++) rd();
        // pop and write at count 1
        drive(1'b1, 32'h2000_0004, 1'b1, 1'b0);
        check("t5.c1_empty", 64'(empty), 64'd0);
        rd();
        // underflow, then clear racing a new underflow
        rd();
        check("t5.underflow", 64'(underflow), 64'd1);
        drive(1'b0, '0, 1'b1, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b1);
        // sub-word pointer still at zero: 8b word needs all 4 reads
        input_bitwidth = 3'b100;
        wr(32'h3000_0000);
        for (int i = 0; i < 4; i++) rd();

        // async reset mid-word
        wr(32'h4000_0000);
        rd();
        rd();
        #2;
        nRST = 1'b0;
        #1;
        model_reset();
        check("t6.empty", 64'(empty), 64'd1);
        check("t6.count", 64'(count), 64'd0);
        check("t6.rdata", 64'(rdata), 64'd0);
        check("t6.flags", 64'({overflow, underflow}), 64'd0);
        #3;
        nRST = 1'b1;
        @(posedge clk);
        #1;
        wr(32'h5000_0000);
        for (int i = 0; i < 4; i++) rd();

        // random traffic, including mid-word width changes
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 7))
                0:       input_bitwidth = 3'b001;
                1:       input_bitwidth = 3'b010;
                2:       input_bitwidth = 3'b100;
                3:       input_bitwidth = 3'b111;
                default: ;
            endcase
            drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 9) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
